// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start(1) + WIDTH data bits + stop(0), one bit per bit_en strobe.
// Optional even-parity bit between data and stop when SER_RX_PARITY_EN is defined.
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SER_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH:0]   ext;
    logic             stop_hit;
    logic             word_err;
    logic             load;
    logic             drop;

    // Widen by one bit so the shift works for WIDTH=1 as well
    always_comb begin
        ext     = '0;
        sh_next = '0;
        if (LSB_FIRST) begin
            ext     = {ser_in, shreg};
            sh_next = ext[WIDTH:1];
        end else begin
            ext     = {shreg, ser_in};
            sh_next = ext[WIDTH-1:0];
        end
    end

`ifdef SER_RX_PARITY_EN
    logic par_err;
    assign word_err = ser_in | par_err;
`else
    assign word_err = ser_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
`ifdef SER_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (ser_in) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shreg <= sh_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SER_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SER_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to zero
                    par_err <= (^shreg) ^ ser_in;
                    state   <= STOP;
                end
`endif
                STOP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign stop_hit = bit_en && (state == STOP);
    assign load     = stop_hit && (!data_valid || data_ready);
    assign drop     = stop_hit && data_valid && !data_ready;

    // Single-entry output buffer; a new word is dropped rather than overwriting an unread one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= shreg;
                frame_err  <= word_err;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized bench for serial_frame_receiver with a frame-level reference model
// (collected bit queue -> word) plus directed checks with hand-computed values.
module tb_serial_frame_receiver;

    localparam int W   = 4;
    localparam bit LSB = 1'b1;
`ifdef SER_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FLEN = W + 2 + PB;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ser_in = 1'b0;
    logic         bit_en = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic         frame_err;
    logic         overrun;
    logic         clr_err = 1'b0;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    serial_frame_receiver #(.WIDTH(W), .LSB_FIRST(LSB)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .bit_en(bit_en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bits collected in a queue, word built when the frame is complete
    bit           frm[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic         m_ovr = 1'b0;

    always @(posedge clk) begin
        bit           done;
        logic [W-1:0] w;
        bit           e;
        done = 1'b0;
        w    = '0;
        e    = 1'b0;
        if (!reset) begin
            frm.delete();
            m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        end else begin
            if (bit_en) begin
                if (frm.size() == 0) begin
                    if (ser_in) frm.push_back(1'b1);
                end else begin
                    frm.push_back(ser_in);
                    if (frm.size() == FLEN) begin
                        int ones;
                        ones = 0;
                        for (int i = 0; i < W; i++) begin
                            if (LSB) w[i] = frm[1+i];
                            else     w[W-1-i] = frm[1+i];
                            ones += frm[1+i];
                        end
                        if (PB != 0) ones += frm[1+W];
                        e = (frm[FLEN-1] != 1'b0) || (PB != 0 && (ones % 2) != 0);
                        done = 1'b1;
                        frm.delete();
                    end
                end
            end
            if (done && m_valid && !data_ready) begin
                m_ovr = 1'b1;
            end else begin
                if (done) begin
                    m_data = w; m_err = e; m_valid = 1'b1;
                end else if (m_valid && data_ready) begin
                    m_valid = 1'b0;
                end
                if (clr_err) m_ovr = 1'b0;
            end
        end
        #1;
        chk("data_valid", data_valid, m_valid);
        chk("data_out",   data_out,   m_data);
        chk("frame_err",  frame_err,  m_err);
        chk("overrun",    overrun,    m_ovr);
        chk("busy",       busy,       frm.size() > 0);
    end

    always @(negedge clk) begin
        if (rand_mode) begin
            data_ready = ($urandom_range(0, 3) == 0);
            clr_err    = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic strobe(input logic b, input int gap);
        ser_in = b; bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            ser_in = ~ser_in;
            @(negedge clk);
        end
    endtask

    // Sends bits[n-1] first
    task automatic send(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) strobe(bits[i], gap);
    endtask

    task automatic pulse_ready();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst data_valid", data_valid, 1'b0);
        chk("rst data_out",   data_out,   4'h0);
        chk("rst busy",       busy,       1'b0);
        chk("rst overrun",    overrun,    1'b0);
        chk("rst frame_err",  frame_err,  1'b0);
        reset = 1'b1;
        @(negedge clk);

`ifndef SER_RX_PARITY_EN
        // Basic frame, data_valid only after the sixth strobe
        send(16'b10011, 5, 0);
        chk("basic not yet valid", data_valid, 1'b0);
        chk("basic busy in stop",  busy,       1'b1);
        send(16'b0, 1, 0);
        chk("basic valid", data_valid, 1'b1);
        chk("basic data",  data_out,   4'hC);
        chk("basic ferr",  frame_err,  1'b0);
        chk("basic idle",  busy,       1'b0);
        pulse_ready();
        chk("basic accepted", data_valid, 1'b0);

        // Gapped strobes with line toggling between them
        send(16'b1, 1, 3);
        chk("gap busy after start", busy, 1'b1);
        send(16'b0011, 4, 3);
        chk("gap busy before stop", busy, 1'b1);
        chk("gap not yet valid", data_valid, 1'b0);
        send(16'b0, 1, 0);
        chk("gap data",  data_out,   4'hC);
        chk("gap valid", data_valid, 1'b1);
        chk("gap idle",  busy,       1'b0);
        pulse_ready();

        // Framing error, then a good frame
        send(16'b110101, 6, 0);
        chk("ferr valid", data_valid, 1'b1);
        chk("ferr data",  data_out,   4'h5);
        chk("ferr flag",  frame_err,  1'b1);
        pulse_ready();
        send(16'b111110, 6, 0);
        chk("good data", data_out,  4'hF);
        chk("good flag", frame_err, 1'b0);
        pulse_ready();

        // Overrun: second word dropped, first kept
        send(16'b111000, 6, 0);
        send(16'b101010, 6, 0);
        chk("ovr data",  data_out,   4'h3);
        chk("ovr valid", data_valid, 1'b1);
        chk("ovr flag",  overrun,    1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr cleared", overrun, 1'b0);
        pulse_ready();

        // Reset mid-frame
        send(16'b110, 3, 0);
        chk("pre-reset busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst busy",  busy,       1'b0);
        chk("midrst valid", data_valid, 1'b0);
        chk("midrst data",  data_out,   4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst no word", data_valid, 1'b0);
        send(16'b101100, 6, 0);
        chk("postrst data", data_out, 4'h6);
        chk("postrst ferr", frame_err, 1'b0);
        pulse_ready();
`else
        send(16'b1001100, 7, 0);
        chk("par ok data", data_out,  4'hC);
        chk("par ok ferr", frame_err, 1'b0);
        pulse_ready();
        send(16'b1001110, 7, 0);
        chk("par bad data", data_out,  4'hC);
        chk("par bad ferr", frame_err, 1'b1);
        pulse_ready();
`endif

        // Randomized frames against the model
        rand_mode = 1'b1;
        for (int f = 0; f < 250; f++) begin
            bit           fb[$];
            logic [W-1:0] w;
            int           g;
            int           rst_at;
            w  = W'($urandom);
            g  = $urandom_range(0, 2);
            fb.push_back(1'b1);
            for (int i = 0; i < W; i++) fb.push_back(LSB ? w[i] : w[W-1-i]);
            if (PB != 0) fb.push_back(($urandom_range(0, 3) == 0) ? ~(^w) : (^w));
            fb.push_back($urandom_range(0, 5) == 0);
            rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, FLEN - 1)) : -1;
            for (int i = 0; i < fb.size(); i++) begin
                if (i == rst_at) begin
                    reset = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    break;
                end
                strobe(fb[i], g);
            end
            repeat ($urandom_range(0, 2)) strobe(1'b0, $urandom_range(0, 1));
        end
        rand_mode = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
